// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU and its NZCV flags register between two requesters.
// Optional grant locking is compiled in with ALU_ARB_LOCK_EN.
module alu_arbiter #(
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [1:0][3:0]       req_opcode,
  input  logic [1:0][WIDTH-1:0] req_op1,
  input  logic [1:0][WIDTH-1:0] req_op2,
`ifdef ALU_ARB_LOCK_EN
  input  logic [1:0]            lock,
`endif
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_err,
  output logic                  alu_start,
  output logic [3:0]            alu_opcode,
  output logic [WIDTH-1:0]      alu_op1,
  output logic [WIDTH-1:0]      alu_op2,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_done,
  output logic                  flags_load
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t     state;
  logic       ptr;
  logic       owner;
  logic       grant_id;
  logic       ptr_next;
  logic [8:0] wd_cnt;
  logic       wd_expire;

  // The counter is cleared as alu_start is launched, so expiry lands TIMEOUT+1
  // WAIT cycles later and the error response appears TIMEOUT+2 cycles after start.
  assign wd_expire = (wd_cnt == 9'(TIMEOUT + 1));

  always_comb begin
    grant_id = 1'b0;
    if (req_valid == 2'b11)
      grant_id = ptr;
    else if (req_valid[1])
      grant_id = 1'b1;
  end

`ifdef ALU_ARB_LOCK_EN
  // A held lock keeps the pointer on the owner; dropping req_valid lets the other side win.
  assign ptr_next = lock[owner] ? owner : ~owner;
`else
  assign ptr_next = ~owner;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      wd_cnt     <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      alu_start  <= 1'b0;
      alu_opcode <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      flags_load <= 1'b0;
    end else begin
      req_ready  <= '0;
      rsp_valid  <= '0;
      alu_start  <= 1'b0;
      flags_load <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner               <= grant_id;
            req_ready[grant_id] <= 1'b1;
            alu_opcode          <= req_opcode[grant_id];
            alu_op1             <= req_op1[grant_id];
            alu_op2             <= req_op2[grant_id];
            rsp_err             <= 1'b0;
            state               <= ISSUE;
          end
        end
        ISSUE: begin
          alu_start <= 1'b1;
          wd_cnt    <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          wd_cnt <= wd_cnt + 9'd1;
          // Completion takes priority over a watchdog expiring in the same cycle.
          if (alu_done) begin
            rsp_result       <= alu_result;
            rsp_err          <= 1'b0;
            rsp_valid[owner] <= 1'b1;
            flags_load       <= 1'b1;
            state            <= WB;
          end else if (wd_expire) begin
            rsp_result       <= '0;
            rsp_err          <= 1'b1;
            rsp_valid[owner] <= 1'b1;
            state            <= WB;
          end
        end
        WB: begin
          ptr   <= ptr_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single op, stray done, timeout, done/expiry race,
// reset mid-operation and round-robin contention.
module tb_alu_arbiter;
  localparam int WIDTH = 12;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            req_valid;
  logic [1:0][3:0]       req_opcode;
  logic [1:0][WIDTH-1:0] req_op1;
  logic [1:0][WIDTH-1:0] req_op2;
  logic [1:0]            req_ready;
  logic [1:0]            rsp_valid;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_err;
  logic                  alu_start;
  logic [3:0]            alu_opcode;
  logic [WIDTH-1:0]      alu_op1;
  logic [WIDTH-1:0]      alu_op2;
  logic [WIDTH-1:0]      alu_result;
  logic                  alu_done;
  logic                  flags_load;

  int total = 0;
  int bad   = 0;
  int fl_cnt = 0;

  alu_arbiter #(.WIDTH(WIDTH), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_opcode(req_opcode),
    .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_start(alu_start), .alu_opcode(alu_opcode),
    .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_done(alu_done),
    .flags_load(flags_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (flags_load === 1'b1) fl_cnt <= fl_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    int fl_base;
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;

    rst_n = 1'b0; req_valid = '0; req_opcode = '0; req_op1 = '0; req_op2 = '0;
    alu_result = '0; alu_done = 1'b0;
    cyc(); cyc();
    // Reset state
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_alu_start", 32'(alu_start), 32'h0);
    chk("rst_flags_load", 32'(flags_load), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_result", 32'(rsp_result), 32'h0);
    chk("rst_alu_op1", 32'(alu_op1), 32'h0);
    rst_n = 1'b1;
    cyc();

    // Single op from requester 0, ALU answers two cycles after start
    req_valid = 2'b01; req_opcode[0] = 4'b1001; req_op1[0] = 12'h7FF; req_op2[0] = 12'h001;
    cyc();                                          // c0
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_start_c0", 32'(alu_start), 32'h0);
    req_valid = 2'b00;
    cyc();                                          // c1
    chk("single_start", 32'(alu_start), 32'h1);
    chk("single_opcode", 32'(alu_opcode), 32'h9);
    chk("single_op1", 32'(alu_op1), 32'h7FF);
    chk("single_op2", 32'(alu_op2), 32'h001);
    cyc();                                          // c2
    chk("single_start_once", 32'(alu_start), 32'h0);
    chk("single_ready_once", 32'(req_ready), 32'h0);
    cyc();                                          // c3
    alu_done = 1'b1; alu_result = 12'h800;
    cyc();                                          // c4
    alu_done = 1'b0;
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_flags_load", 32'(flags_load), 32'h1);
    chk("single_result", 32'(rsp_result), 32'h800);
    chk("single_err", 32'(rsp_err), 32'h0);
    chk("single_opcode_wb", 32'(alu_opcode), 32'h9);
    cyc();                                          // c5, IDLE
    chk("single_rsp_once", 32'(rsp_valid), 32'h0);
    chk("single_flags_once", 32'(flags_load), 32'h0);

    // Stray done while idle must be ignored
    alu_done = 1'b1;
    cyc();
    alu_done = 1'b0;
    chk("stray_rsp", 32'(rsp_valid), 32'h0);
    chk("stray_flags", 32'(flags_load), 32'h0);
    chk("stray_start", 32'(alu_start), 32'h0);

    // Timeout from requester 1: response with error at start+17, no flags load
    req_valid = 2'b10; req_opcode[1] = 4'h3; req_op1[1] = 12'h123; req_op2[1] = 12'h456;
    fl_base = fl_cnt;
    cyc();                                          // c0
    chk("to_ready", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    cyc();                                          // c1
    chk("to_start", 32'(alu_start), 32'h1);
    for (int c = 2; c <= 17; c++) cyc();            // c17
    chk("to_not_early", 32'(rsp_valid), 32'h0);
    cyc();                                          // c18
    chk("to_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("to_err", 32'(rsp_err), 32'h1);
    chk("to_flags", 32'(flags_load), 32'h0);
    cyc();
    chk("to_rsp_once", 32'(rsp_valid), 32'h0);
    chk("to_no_flags", 32'(fl_cnt - fl_base), 32'h0);

    // Done on the expiry cycle: completion wins
    req_valid = 2'b01; req_opcode[0] = 4'h5; req_op1[0] = 12'h00F; req_op2[0] = 12'h0F0;
    cyc();                                          // c0
    chk("race_ready", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    for (int c = 1; c <= 17; c++) cyc();            // c17
    chk("race_not_early", 32'(rsp_valid), 32'h0);
    alu_done = 1'b1; alu_result = 12'h0AB;
    cyc();                                          // c18
    alu_done = 1'b0;
    chk("race_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("race_err", 32'(rsp_err), 32'h0);
    chk("race_flags", 32'(flags_load), 32'h1);
    chk("race_result", 32'(rsp_result), 32'h0AB);
    cyc();

    // Reset while in WAIT abandons the operation
    req_valid = 2'b10; req_opcode[1] = 4'hC; req_op1[1] = 12'hABC; req_op2[1] = 12'h321;
    cyc();                                          // c0
    req_valid = 2'b00;
    cyc(); cyc(); cyc();                            // c3, WAIT
    chk("mid_opcode_before", 32'(alu_opcode), 32'hC);
    fl_base = fl_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_opcode", 32'(alu_opcode), 32'h0);
    chk("mid_rst_op1", 32'(alu_op1), 32'h0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
    chk("mid_rst_flags", 32'(flags_load), 32'h0);
    alu_done = 1'b1; alu_result = 12'hFFF;
    cyc();
    alu_done = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
    chk("mid_no_flags", 32'(fl_cnt - fl_base), 32'h0);

    // Contention after reset: grants alternate 0,1,0,1, each completing normally
    req_valid = 2'b11;
    req_opcode[0] = 4'h2; req_op1[0] = 12'h010; req_op2[0] = 12'h020;
    req_opcode[1] = 4'hA; req_op1[1] = 12'h100; req_op2[1] = 12'h200;
    fl_base = fl_cnt;
    for (int i = 0; i < 4; i++) begin
      cyc();                                        // c0
      chk($sformatf("rr_grant%0d", i), 32'(req_ready), 32'(exp_g[i]));
      cyc();                                        // c1
      chk($sformatf("rr_opcode%0d", i), 32'(alu_opcode), (exp_g[i] == 2'b01) ? 32'h2 : 32'hA);
      cyc();                                        // c2
      alu_done = 1'b1; alu_result = 12'(12'h111 * (i + 1));
      cyc();                                        // c3
      alu_done = 1'b0;
      chk($sformatf("rr_rsp%0d", i), 32'(rsp_valid), 32'(exp_g[i]));
      chk($sformatf("rr_result%0d", i), 32'(rsp_result), 32'(12'h111 * (i + 1)));
      if (i == 3) req_valid = 2'b00;
      cyc();                                        // c4, IDLE
    end
    cyc(); cyc();
    chk("rr_flags_count", 32'(fl_cnt - fl_base), 32'd4);
    chk("rr_idle_ready", 32'(req_ready), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
